// File: rtl/trip_collector_if.sv
// rtl/trip_collector_if.sv - trip-byte write channel between instrumentation divisions and collector
//
// Purpose: bundles the trip-byte write handshake.
// Signals:
//   in_valid  division presents a trip-byte write
//   in_ready  collector accepts the write this cycle
//   in_div    source division 0..3
//   in_ch     channel: 0 temperature, 1 pressure, 2 saturation, 3 reserved
//   in_trip   trip byte, nonzero = tripped
// Modports: master = division side, slave = collector side.

interface trip_collector_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_div;
  logic [1:0] in_ch;
  logic [7:0] in_trip;

  modport master (
    output in_valid,
    output in_div,
    output in_ch,
    output in_trip,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_div,
    input  in_ch,
    input  in_trip,
    output in_ready
  );
endinterface

// File: rtl/trip_collector.sv
// rtl/trip_collector.sv - collects per-division trip bytes into a fail-safe actuation vector
//
// Purpose: stores trip bytes from four divisions x three channels, tracks
// per-division staleness, applies single-division maintenance bypass and
// publishes a registered 96-bit trip vector.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus           trip-byte write channel (slave side)
//   maint         per-division maintenance bypass request
//   trips         trip vector: [95:64] temp, [63:32] pressure, [31:0] saturation,
//                 division d at byte 3-d within each field
//   trips_valid   every division has reported since reset
//   stale         per-division staleness flags
//   bypass_err    more than one maintenance bit requested
//   ch_err        one-cycle pulse on an accepted reserved-channel write

module trip_collector #(
  parameter int unsigned STALE_LIMIT = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  trip_collector_if.slave        bus,
  input  logic [3:0]             maint,
  output logic [95:0]            trips,
  output logic                   trips_valid,
  output logic [3:0]             stale,
  output logic                   bypass_err,
  output logic                   ch_err
);

  localparam logic [15:0] LIMIT   = 16'(STALE_LIMIT);
  localparam logic [1:0]  CH_RSVD = 2'd3;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                 state;
  logic                   ready;
  logic [3:0]             seen;
  logic [3:0][2:0][7:0]   store;
  logic [3:0][2:0][7:0]   store_nxt;
  logic [3:0][15:0]       age;
  logic [3:0][15:0]       age_nxt;
  logic [3:0]             stale_nxt;
  logic [95:0]            trips_nxt;
  logic                   accept;
  logic                   wr_store;
  logic                   bypass_one;
  logic                   bypass_multi;

  // Ready is a register so nothing is accepted on the first clock after
  // reset is released.
  assign bus.in_ready = ready;
  assign accept       = bus.in_valid & ready;
  assign wr_store     = accept && (bus.in_ch != CH_RSVD);

  // Exactly one bit set: x & (x-1) clears the lowest set bit.
  assign bypass_one   = (maint != 4'b0000) && ((maint & (maint - 4'd1)) == 4'b0000);
  assign bypass_multi = (maint != 4'b0000) && !bypass_one;

  always_comb begin
    store_nxt = store;
    if (wr_store) begin
      store_nxt[bus.in_div][bus.in_ch] = bus.in_trip;
    end
  end

  // Age and staleness are computed from next-state values so that the
  // registered stale flag lines up with the registered age, and an accept
  // in the crossing cycle wins.
  always_comb begin
    age_nxt   = age;
    stale_nxt = 4'b0000;
    for (int d = 0; d < 4; d++) begin
      if (accept && (bus.in_div == 2'(d))) begin
        age_nxt[d] = 16'd0;
      end else if (age[d] != 16'hFFFF) begin
        age_nxt[d] = age[d] + 16'd1;
      end
      stale_nxt[d] = (age_nxt[d] >= LIMIT);
    end
  end

  // Output byte priority: stale (fail-safe trip) > bypass (zero) > stored.
  always_comb begin
    trips_nxt = 96'h0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 3; c++) begin
        if (stale_nxt[d]) begin
          trips_nxt[(2 - c) * 32 + 8 * (3 - d) +: 8] = 8'hFF;
        end else if (bypass_one && maint[d]) begin
          trips_nxt[(2 - c) * 32 + 8 * (3 - d) +: 8] = 8'h00;
        end else begin
          trips_nxt[(2 - c) * 32 + 8 * (3 - d) +: 8] = store_nxt[d][c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      ready       <= 1'b0;
      seen        <= 4'b0000;
      store       <= '0;
      age         <= '0;
      stale       <= 4'b0000;
      trips       <= 96'h0;
      trips_valid <= 1'b0;
      bypass_err  <= 1'b0;
      ch_err      <= 1'b0;
    end else begin
      ready      <= 1'b1;
      store      <= store_nxt;
      age        <= age_nxt;
      stale      <= stale_nxt;
      trips      <= trips_nxt;
      bypass_err <= bypass_multi;
      ch_err     <= accept && (bus.in_ch == CH_RSVD);
      if (accept) begin
        seen[bus.in_div] <= 1'b1;
      end
      case (state)
        S_INIT: begin
          trips_valid <= 1'b0;
          if (seen == 4'hF) begin
            state       <= S_RUN;
            trips_valid <= 1'b1;
          end
        end
        S_RUN: begin
          trips_valid <= 1'b1;
        end
        default: begin
          state       <= S_INIT;
          trips_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
